// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
//
// Shares one 8-digit multiplexed seven-segment display between two
// requesters. Ownership is granted round-robin. An owner keeps the display
// for a minimum tenure whenever the other side is waiting. Every hand-over
// inserts a blank gap, including when the same owner is granted again.
//
// Request/grant protocol: req[k] is a level. The requester holds it high for
// as long as it wants the display. grant[k] is a registered level that is
// high only while requester k owns the display. At most one grant bit is set.
// Dropping req[k] releases ownership. There is no per-transfer handshake.
//
// Ports
//   clk        in   clock, all logic on the rising edge
//   reset      in   synchronous, active-low
//   req[1:0]   in   per-requester request level
//   value0/1   in   8 hex nibbles, digit d = value[4d+3:4d], d=0 rightmost
//   dots0/1    in   per-digit decimal point, bit d high = dot lit
//   grant[1:0] out  registered owner indication, one-hot or zero
//   segments   out  active-low {g,f,e,d,c,b,a}
//   dot_point  out  active-low decimal point
//   anodes     out  active-low digit enables
module seg_display_arbiter #(
    parameter int SCAN_BITS    = 16,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int BLANK_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [31:0] value0,
    input  logic [7:0]  dots0,
    input  logic [31:0] value1,
    input  logic [7:0]  dots1,
    output logic [1:0]  grant,
    output logic [6:0]  segments,
    output logic        dot_point,
    output logic [7:0]  anodes
);

    // Hold counter saturates at HOLD_CYCLES, so it needs room for that value.
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        BLANK = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    state_t          arb_pick;
    logic            last;        // last owner, round-robin pointer
    logic            last_next;
    logic [HW-1:0]   hold_cnt;
    logic [HW-1:0]   hold_next;
    logic [BW-1:0]   blank_cnt;
    logic [BW-1:0]   blank_next;
    logic [SCAN_BITS-1:0] scan;
    logic            hold_done;

    // Round-robin choice among the current requests. A tie goes to the
    // requester that did not own the display last.
    function automatic state_t arbitrate(input logic [1:0] r, input logic l);
        state_t s;
        case (r)
            2'b01:   s = OWN0;
            2'b10:   s = OWN1;
            2'b11:   s = l ? OWN0 : OWN1;
            default: s = IDLE;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] hexmap(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // The counter starts at 0 on entry, so reaching HOLD_CYCLES-1 marks the
    // HOLD_CYCLES-th owned cycle. That cycle's edge is the earliest preemption.
    assign hold_done = (hold_cnt >= HOLD_LAST);
    assign arb_pick  = arbitrate(req, last);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            hold_cnt  <= '0;
            blank_cnt <= '0;
        end else begin
            state     <= state_next;
            last      <= last_next;
            hold_cnt  <= hold_next;
            blank_cnt <= blank_next;
        end
    end

    always_comb begin
        state_next = state;
        last_next  = last;
        hold_next  = hold_cnt;
        blank_next = blank_cnt;

        case (state)
            IDLE: begin
                state_next = arb_pick;
            end
            OWN0: begin
                if (!req[0] || (req[1] && hold_done)) begin
                    state_next = BLANK;
                    blank_next = '0;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_next = hold_cnt + HW'(1);
                end
            end
            OWN1: begin
                if (!req[1] || (req[0] && hold_done)) begin
                    state_next = BLANK;
                    blank_next = '0;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_next = hold_cnt + HW'(1);
                end
            end
            default: begin // BLANK
                // Requests are only looked at in the final gap cycle.
                if (blank_cnt == BLANK_LAST) begin
                    state_next = arb_pick;
                end else begin
                    blank_next = blank_cnt + BW'(1);
                end
            end
        endcase

        // Entering an owner state: record the owner and restart its tenure.
        if ((state_next == OWN0 || state_next == OWN1) && state_next != state) begin
            last_next = (state_next == OWN1);
            hold_next = '0;
        end
    end

    // ------------------------------------------------------- display scan
    logic [2:0]  digit;
    logic [31:0] own_value;
    logic [7:0]  own_dots;
    logic [31:0] shifted;

    assign digit     = scan[SCAN_BITS-1 -: 3];
    // The display follows the registered grant, which puts it one cycle
    // behind the grant output.
    assign own_value = grant[1] ? value1 : value0;
    assign own_dots  = grant[1] ? dots1  : dots0;
    assign shifted   = own_value >> {digit, 2'b00};

    always_ff @(posedge clk) begin
        if (!reset) begin
            scan      <= '0;
            grant     <= 2'b00;
            anodes    <= 8'hFF;
            segments  <= 7'h7F;
            dot_point <= 1'b1;
        end else begin
            scan <= scan + SCAN_BITS'(1);
            case (state)
                OWN0:    grant <= 2'b01;
                OWN1:    grant <= 2'b10;
                default: grant <= 2'b00;
            endcase
            if (grant != 2'b00) begin
                anodes    <= ~(8'b1 << digit);
                segments  <= hexmap(shifted[3:0]);
                dot_point <= ~own_dots[digit];
            end else begin
                anodes    <= 8'hFF;
                segments  <= 7'h7F;
                dot_point <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter. It uses a behavioural owner/tenure/gap
// model that is updated at every clock edge. Directed scenarios are followed
// by a randomized request phase.
module tb_seg_display_arbiter;
    localparam int SB    = 6;
    localparam int HOLD  = 20;
    localparam int BLANK = 4;
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [31:0] value0, value1;
    logic [7:0]  dots0, dots1;
    logic [1:0]  grant;
    logic [6:0]  segments;
    logic        dot_point;
    logic [7:0]  anodes;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_display_arbiter #(
        .SCAN_BITS(SB), .HOLD_CYCLES(HOLD), .BLANK_CYCLES(BLANK)
    ) dut (
        .clk(clk), .reset(reset), .req(req),
        .value0(value0), .dots0(dots0), .value1(value1), .dots1(dots1),
        .grant(grant), .segments(segments), .dot_point(dot_point), .anodes(anodes)
    );

    // Reference model: mode 0 = nobody owns, 1 = owned, 2 = hand-over gap.
    int         m_mode   = 0;
    int         m_owner  = 0;
    int         m_last   = 1;
    int         m_tenure = 0;  // owned cycles so far, counting the current one
    int         m_gap    = 0;  // gap cycles so far, counting the current one
    int         m_scan   = 0;
    logic [1:0] e_grant  = 2'b00;
    logic [7:0] e_an     = 8'hFF;
    logic [6:0] e_seg    = 7'h7F;
    logic       e_dp     = 1'b1;

    function automatic int pick(input logic [1:0] r, input int last_owner);
        if (r == 2'b11) return (last_owner == 0) ? 1 : 0;
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        return -1;
    endfunction

    task automatic take_owner(input int p);
        m_mode   = 1;
        m_owner  = p;
        m_last   = p;
        m_tenure = 1;
    endtask

    task automatic model_edge();
        int         d;
        int         p;
        logic [31:0] v;
        logic [7:0]  dm;
        if (!reset) begin
            m_mode = 0; m_last = 1; m_scan = 0; m_tenure = 0; m_gap = 0;
            e_grant = 2'b00; e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
            return;
        end
        // Display uses the grant value held before this edge.
        if (e_grant != 2'b00) begin
            v  = e_grant[1] ? value1 : value0;
            dm = e_grant[1] ? dots1 : dots0;
            d  = m_scan / (1 << (SB - 3));
            e_an  = ~(8'(1) << d);
            e_seg = HEX[int'((v >> (4 * d)) & 32'hF)];
            e_dp  = ~dm[d];
        end else begin
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
        end
        e_grant = (m_mode == 1) ? ((m_owner == 0) ? 2'b01 : 2'b10) : 2'b00;
        case (m_mode)
            0: begin
                p = pick(req, m_last);
                if (p >= 0) take_owner(p);
            end
            1: begin
                if (!req[m_owner] || (req[1 - m_owner] && m_tenure >= HOLD)) begin
                    m_mode = 2;
                    m_gap  = 1;
                end else begin
                    m_tenure++;
                end
            end
            default: begin
                if (m_gap >= BLANK) begin
                    p = pick(req, m_last);
                    if (p >= 0) take_owner(p);
                    else m_mode = 0;
                end else begin
                    m_gap++;
                end
            end
        endcase
        m_scan = (m_scan + 1) % (1 << SB);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: update the model at the edge, then compare just after it.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("grant", {30'd0, grant}, {30'd0, e_grant});
        chk("anodes", {24'd0, anodes}, {24'd0, e_an});
        chk("segments", {25'd0, segments}, {25'd0, e_seg});
        chk("dot_point", {31'd0, dot_point}, {31'd0, e_dp});
    endtask

    task automatic wait_grant(input string tag, input logic [1:0] g);
        int n = 0;
        while (grant !== g && n < 100) begin
            cycle();
            n++;
        end
        chk(tag, {30'd0, grant}, {30'd0, g});
    endtask

    task automatic run_len(input logic [1:0] g, output int n);
        n = 0;
        while (grant === g && n < 300) begin
            cycle();
            n++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"}, {30'd0, grant}, 32'h0);
        chk({tag, "_anodes"}, {24'd0, anodes}, 32'hFF);
        chk({tag, "_segments"}, {25'd0, segments}, 32'h7F);
        chk({tag, "_dot"}, {31'd0, dot_point}, 32'h1);
    endtask

    initial begin
        int n;
        reset = 1'b0; req = 2'b00;
        value0 = '0; value1 = '0; dots0 = '0; dots1 = '0;
        cycle(); cycle();
        check_reset_outputs("reset");
        reset = 1'b1;

        // Idle with no requests.
        for (int i = 0; i < 100; i++) begin
            cycle();
            chk("idle_grant", {30'd0, grant}, 32'h0);
            chk("idle_anodes", {24'd0, anodes}, 32'hFF);
        end

        // Single requester 0: two-edge grant latency, then a full scan.
        value0 = 32'h76543210; dots0 = 8'h01; req = 2'b01;
        cycle();
        chk("grant_early", {30'd0, grant}, 32'h0);
        cycle();
        chk("grant_latency", {30'd0, grant}, 32'h1);
        for (int i = 0; i < 70; i++) cycle();
        req = 2'b00;
        for (int i = 0; i < 10; i++) cycle();

        // Both requesting from reset: 0 first, hand-over after HOLD + BLANK.
        reset = 1'b0; cycle(); reset = 1'b1;
        req = 2'b11;
        wait_grant("first_owner", 2'b01);
        run_len(2'b01, n); chk("hold0_len", n, HOLD);
        run_len(2'b00, n); chk("gap0_len", n, BLANK);
        chk("second_owner", {30'd0, grant}, 32'h2);
        run_len(2'b10, n); chk("hold1_len", n, HOLD);
        run_len(2'b00, n); chk("gap1_len", n, BLANK);
        chk("third_owner", {30'd0, grant}, 32'h1);

        // Voluntary release by requester 1, then re-grant from idle.
        req = 2'b10;
        wait_grant("own1", 2'b10);
        for (int i = 0; i < 4; i++) cycle();
        req = 2'b00;
        cycle();
        chk("release_edge", {30'd0, grant}, 32'h2);
        for (int i = 0; i < 12; i++) begin
            cycle();
            chk("release_gap", {30'd0, grant}, 32'h0);
        end
        req = 2'b10;
        cycle(); cycle();
        chk("regrant", {30'd0, grant}, 32'h2);

        // Requester 1 content, then a one-cycle value change latency.
        value1 = 32'hFEDCBA98; dots1 = 8'h5A;
        for (int i = 0; i < 70; i++) cycle();
        value1 = 32'h0;
        cycle();
        chk("value_latency", {25'd0, segments}, 32'h40);
        for (int i = 0; i < 10; i++) cycle();

        // Reset during the gap and during an owned period.
        req = 2'b00;
        cycle(); cycle();
        reset = 1'b0; cycle();
        check_reset_outputs("rst_blank");
        reset = 1'b1; req = 2'b01;
        wait_grant("own0_again", 2'b01);
        for (int i = 0; i < 3; i++) cycle();
        reset = 1'b0; cycle();
        check_reset_outputs("rst_own");
        reset = 1'b1; req = 2'b11;
        cycle(); cycle();
        chk("post_reset_rr", {30'd0, grant}, 32'h1);

        // Randomized requests, content and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) req = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) value0 = $urandom;
            if ($urandom_range(0, 5) == 0) value1 = $urandom;
            if ($urandom_range(0, 9) == 0) dots0 = 8'($urandom);
            if ($urandom_range(0, 9) == 0) dots1 = 8'($urandom);
            reset = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
